// File: rtl/mmio_outport_if.sv
// Core data-bus, external-memory and consumer-handshake signals of the memory-mapped output port.
interface mmio_outport_if #(
  parameter int WIDTH = 8
);
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata_in;
  logic [WIDTH-1:0] memdata;
  logic             mem_we;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  modport slave (
    input  memwrite, adr, writedata, memdata_in, out_ready,
    output memdata, mem_we, out_data, out_valid, overflow
  );

  modport master (
    output memwrite, adr, writedata, memdata_in, out_ready,
    input  memdata, mem_we, out_data, out_valid, overflow
  );
endinterface

// File: rtl/mmio_outport.sv
// Output port FIFO and status register on the core data bus.
// All other addresses pass through to external memory.
module mmio_outport #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int PORTADR = 255,
  parameter int STATADR = 254
) (
  input logic         clk,
  input logic         reset,
  mmio_outport_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [WIDTH-1:0] PORT_A   = WIDTH'(PORTADR);
  localparam logic [WIDTH-1:0] STAT_A   = WIDTH'(STATADR);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow_q;

  logic hit_port, hit_stat, full, empty;
  logic push, pop, push_ok, ovf_set, ovf_clr;
  logic [WIDTH-1:0] status;

  assign hit_port = (bus.adr == PORT_A);
  assign hit_stat = (bus.adr == STAT_A);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

  assign push    = bus.memwrite & hit_port;
  assign pop     = ~empty & bus.out_ready;
  // A pop in the same cycle frees the slot, so a store to a full FIFO is accepted.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign ovf_clr = bus.memwrite & hit_stat & bus.writedata[7];

  always_comb begin
    status      = '0;
    status[7]   = overflow_q;
    status[6]   = full;
    status[5]   = empty;
    status[3:0] = 4'(count);
  end

  assign bus.mem_we    = bus.memwrite & ~hit_port & ~hit_stat;
  assign bus.memdata   = hit_stat ? status : bus.memdata_in;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = ~empty;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.writedata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_outport.sv
// Bench for mmio_outport: directed scenarios then random traffic against a queue-based model.
module tb_mmio_outport;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int errors = 0;

  mmio_outport_if #(.WIDTH(8)) bus ();

  mmio_outport #(.WIDTH(8), .DEPTH(4), .PORTADR(255), .STATADR(254)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // External byte memory, written only through the DUT's forwarded strobe.
  logic [7:0] ext_ram [256];
  assign bus.memdata_in = ext_ram[bus.adr];
  always @(posedge clk) if (bus.mem_we) ext_ram[bus.adr] <= bus.writedata;

  // Reference model
  logic [7:0] q[$];
  logic       ovf = 1'b0;
  logic [7:0] ref_ram [256];
  logic       cur_we;
  logic [7:0] cur_a, cur_d;
  logic       cur_rdy;

  function automatic logic [7:0] model_status();
    return {ovf, (q.size() == 4), (q.size() == 0), 1'b0, 4'(q.size())};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] a, input logic [7:0] d, input logic rdy);
    cur_we = we; cur_a = a; cur_d = d; cur_rdy = rdy;
    bus.memwrite  = we;
    bus.adr       = a;
    bus.writedata = d;
    bus.out_ready = rdy;
    #1;
    chk("mem_we", bus.mem_we, we && a != 8'd254 && a != 8'd255);
    chk("memdata", bus.memdata, (a == 8'd254) ? model_status() : ref_ram[a]);
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("overflow", bus.overflow, ovf);
    if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
  endtask

  task automatic tick();
    bit popped;
    @(posedge clk);
    popped = (q.size() != 0) && cur_rdy;
    if (cur_we && cur_a != 8'd254 && cur_a != 8'd255) ref_ram[cur_a] = cur_d;
    if (cur_we && cur_a == 8'd254 && cur_d[7]) ovf = 1'b0;
    if (cur_we && cur_a == 8'd255 && q.size() == 4 && !popped) ovf = 1'b1;
    if (popped) void'(q.pop_front());
    if (cur_we && cur_a == 8'd255 && q.size() < 4) q.push_back(cur_d);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    for (int i = 0; i < 256; i++) begin ext_ram[i] = 8'h00; ref_ram[i] = 8'h00; end

    // Reset and idle
    bus.memwrite = 1'b0; bus.adr = 8'd254; bus.writedata = 8'h00; bus.out_ready = 1'b0;
    #7;
    chk("rst_stat", bus.memdata, 8'h20);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("idle_stat", bus.memdata, 8'h20); tick();
    drive(1'b1, 8'd100, 8'h0D, 1'b0); chk("ram_we", bus.mem_we, 1'b1); tick();
    drive(1'b0, 8'd100, 8'h00, 1'b0); chk("ram_rd", bus.memdata, 8'h0D); tick();

    // Single port store, no same-cycle bypass
    drive(1'b1, 8'd255, 8'h0D, 1'b0);
    chk("port_we", bus.mem_we, 1'b0);
    chk("no_bypass", bus.out_valid, 1'b0);
    tick();
    drive(1'b0, 8'd254, 8'h00, 1'b0);
    chk("one_valid", bus.out_valid, 1'b1);
    chk("one_data", bus.out_data, 8'h0D);
    chk("one_stat", bus.memdata, 8'h01);
    tick();
    drive(1'b0, 8'd254, 8'h00, 1'b1); tick();

    // Overfill, then drain
    for (int v = 1; v <= 5; v++) begin drive(1'b1, 8'd255, 8'(v), 1'b0); tick(); end
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("full_stat", bus.memdata, 8'hC4); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd10, 8'h00, 1'b1); chk("drain", bus.out_data, 8'(i + 1)); tick();
    end
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("drained_stat", bus.memdata, 8'hA0); tick();

    // Overflow clear: bit7=0 ignored, bit7=1 clears
    drive(1'b1, 8'd254, 8'h00, 1'b0); chk("clr0_we", bus.mem_we, 1'b0); tick();
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("clr0_stat", bus.memdata, 8'hA0); tick();
    drive(1'b1, 8'd254, 8'h80, 1'b0); chk("clr1_we", bus.mem_we, 1'b0); tick();
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("clr1_stat", bus.memdata, 8'h20); tick();

    // Full FIFO with simultaneous push and pop
    for (int v = 1; v <= 4; v++) begin drive(1'b1, 8'd255, 8'(v), 1'b0); tick(); end
    drive(1'b1, 8'd255, 8'h77, 1'b1); chk("pp_head", bus.out_data, 8'h01); tick();
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("pp_stat", bus.memdata, 8'h44); tick();
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd20, 8'h00, 1'b1); chk("pp_drain", bus.out_data, exp_seq[i]); tick();
    end

    // Async reset with entries pending
    for (int v = 0; v < 3; v++) begin drive(1'b1, 8'd255, 8'hA0 + 8'(v), 1'b0); tick(); end
    drive(1'b0, 8'd254, 8'h00, 1'b1);
    chk("pre_rst_stat", bus.memdata, 8'h03);
    #1 reset = 1'b1;
    #1;
    chk("async_valid", bus.out_valid, 1'b0);
    chk("async_data", bus.out_data, 8'h00);
    chk("async_stat", bus.memdata, 8'h20);
    q.delete(); ovf = 1'b0;
    reset = 1'b0;
    cur_rdy = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'd254, 8'h00, 1'b0); chk("post_rst_stat", bus.memdata, 8'h20); tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      a = (r < 5) ? 8'd255 : (r < 7) ? 8'd254 : 8'($urandom_range(0, 253));
      drive($urandom_range(0, 3) != 0, a, 8'($urandom), $urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
